// File: rtl/ch77_log_pkg.sv
// Shared constants and entry layout for the channel-77 alarm logger.
// Optional build macro: CH77_LOG_DROPCNT_EN (adds the LOG_DROPS counter).
package ch77_log_pkg;

   localparam int ALARM_W   = 9;
   localparam int DEPTH_DEF = 8;
   localparam int TS_W_DEF  = 16;

   // One logged event at the default timestamp width: rising alarm bits in
   // the upper field, timestamp in the lower field.
   typedef struct packed {
      logic [ALARM_W-1:0]  ev;
      logic [TS_W_DEF-1:0] ts;
   } log_entry_t;

endpackage

// File: rtl/ch77_log_fifo.sv
// Entry storage for the alarm logger: circular buffer with show-ahead read.
// A pop on an empty buffer is ignored. A push on a full buffer only lands when
// a pop happens on the same edge. clr empties the buffer and wins over both.
module ch77_log_fifo
   import ch77_log_pkg::*;
#(
   parameter int W     = ALARM_W + TS_W_DEF,
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     clr,
   input  logic [W-1:0]             wdata,
   output logic [W-1:0]             rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = 1;
   localparam logic [AW:0]   CNT_ONE  = 1;
   localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic [W-1:0]  mem_q [DEPTH];
   logic          do_push, do_pop;

   assign empty = (cnt_q == '0);
   assign full  = (cnt_q == FULL_CNT);
   assign count = cnt_q;
   assign rdata = mem_q[rd_ptr_q];

   // Effective push/pop and next pointer/occupancy values.
   always_comb begin
      do_pop   = pop & ~empty & ~clr;
      do_push  = push & (~full | do_pop) & ~clr;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (clr) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
         if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
         case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
         endcase
      end
   end

   // Pointer and occupancy registers; reset empties the buffer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Entry storage; contents are only meaningful between the pointers.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/ch77_alarm_logger.sv
// Channel-77 alarm logger: captures rising alarm bits with a timestamp
// counted from MT01 rising edges and queues them for a host to read.
// Optional build macro: CH77_LOG_DROPCNT_EN adds LOG_DROPS, a saturating
// count of entries lost to a full log.
//
// Host handshake: LOG_RDY is the valid, LOG_ACK the ready. An entry is
// consumed on a clock edge where both are high; LOG_DATA holds the head entry
// and stays stable while LOG_RDY is high and no pop or clear occurs. LOG_ACK
// with LOG_RDY low has no effect.
module ch77_alarm_logger
   import ch77_log_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int TS_W  = TS_W_DEF
) (
   input  logic                      SIM_CLK,
   input  logic                      SIM_RST,
   input  logic [ALARM_W-1:0]        ALARM,
   input  logic                      MT01,
   input  logic                      LOG_ACK,
   input  logic                      LOG_CLR,
   output logic                      LOG_RDY,
   output logic [ALARM_W+TS_W-1:0]   LOG_DATA,
   output logic [$clog2(DEPTH):0]    LOG_CNT,
   output logic                      LOG_OVF
`ifdef CH77_LOG_DROPCNT_EN
   ,
   output logic [7:0]                LOG_DROPS
`endif
);

   localparam logic [TS_W-1:0] TS_ONE = 1;

   logic [ALARM_W-1:0] alarm_q, alarm_d;
   logic               mt01_q, mt01_d;
   logic [TS_W-1:0]    ts_q, ts_d;
   logic               ovf_q, ovf_d;
   logic [ALARM_W-1:0] ev;
   logic               push;
   logic               drop;
   logic               fifo_full, fifo_empty;

   // Rising-edge event vector, timestamp tick and overflow bookkeeping.
   always_comb begin
      alarm_d = ALARM;
      mt01_d  = MT01;
      ev      = ALARM & ~alarm_q;
      // The timestamp captured with an event is the pre-increment value.
      ts_d    = (MT01 & ~mt01_q) ? ts_q + TS_ONE : ts_q;
      // A clear discards any event arriving on the same edge.
      push    = (|ev) & ~LOG_CLR;
      // Full means non-empty, so an ACK always frees a slot for the push.
      drop    = push & fifo_full & ~LOG_ACK;
      ovf_d   = LOG_CLR ? 1'b0 : (ovf_q | drop);
   end

   // Edge-detect history, timestamp and sticky overflow.
   always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
      if (!SIM_RST) begin
         alarm_q <= '0;
         mt01_q  <= 1'b0;
         ts_q    <= '0;
         ovf_q   <= 1'b0;
      end else begin
         alarm_q <= alarm_d;
         mt01_q  <= mt01_d;
         ts_q    <= ts_d;
         ovf_q   <= ovf_d;
      end
   end

`ifdef CH77_LOG_DROPCNT_EN
   logic [7:0] drops_q, drops_d;

   // Saturating count of dropped entries.
   always_comb begin
      drops_d = drops_q;
      if (LOG_CLR)                      drops_d = '0;
      else if (drop && drops_q != 8'hFF) drops_d = drops_q + 8'd1;
   end

   // Drop counter register.
   always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
      if (!SIM_RST) drops_q <= '0;
      else          drops_q <= drops_d;
   end

   assign LOG_DROPS = drops_q;
`endif

   ch77_log_fifo #(
      .W     (ALARM_W + TS_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (SIM_CLK),
      .rst_n (SIM_RST),
      .push  (push),
      .pop   (LOG_ACK),
      .clr   (LOG_CLR),
      .wdata ({ev, ts_q}),
      .rdata (LOG_DATA),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (LOG_CNT)
   );

   assign LOG_RDY = ~fifo_empty;
   assign LOG_OVF = ovf_q;

endmodule

// File: doc/ch77_alarm_logger.md
CH77_ALARM_LOGGER -- requirements
Module: ch77_alarm_logger

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DEPTH, 8, FIFO entries; power of two, 4..32.
- TS_W, 16, timestamp counter width.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- SIM_CLK, in, 1, single clock.
- SIM_RST, in, 1, asynchronous active-low reset.
- ALARM, in, 9, latched channel-77 alarm bits 1..9, synchronous to SIM_CLK.
- MT01, in, 1, time pulse; timestamp tick source.
- LOG_ACK, in, 1, host pops head entry.
- LOG_CLR, in, 1, synchronous clear of log state.
- LOG_RDY, out, 1, FIFO non-empty.
- LOG_DATA, out, 9+TS_W, head entry: event bits in the upper 9 bits, timestamp in the lower TS_W bits.
- LOG_CNT, out, log2(DEPTH)+1, occupancy.
- LOG_OVF, out, 1, sticky overflow flag.
- LOG_DROPS, out, 8, dropped-entry count; present only with CH77_LOG_DROPCNT_EN.

Function
REQ-003 The block SHALL register ALARM every cycle into alarm_q; event vector EV = ALARM & ~alarm_q; falling edges SHALL be ignored.
REQ-004 A nonzero EV SHALL push exactly one entry {EV, ts} at that clock edge; simultaneous bit rises in one cycle SHALL merge into one entry.
REQ-005 ts SHALL increment by 1 on each cycle where MT01 is high and MT01 was low the previous cycle, and SHALL wrap from all-ones to 0.
REQ-006 The captured timestamp SHALL be the ts value present in the cycle EV is nonzero, before any same-edge increment.
REQ-007 Latency: ALARM rises before edge k -> LOG_RDY high and LOG_DATA valid after edge k (1 cycle).
REQ-008 LOG_DATA SHALL present the head entry show-ahead whenever LOG_RDY=1; it is don't-care when empty.
REQ-009 LOG_ACK with LOG_RDY=1 SHALL pop the head at the edge; LOG_ACK when empty SHALL be ignored.
REQ-010 Push when full with no pop SHALL drop the new entry and set LOG_OVF; LOG_OVF SHALL stay set until LOG_CLR or reset.
REQ-011 Push and pop in the same cycle when full SHALL both succeed, with occupancy unchanged and no overflow.
REQ-012 Push and pop in the same cycle when empty SHALL push only; the pop is ignored.
REQ-013 LOG_CLR SHALL empty the FIFO, clear LOG_OVF and LOG_DROPS, and discard any same-cycle event; it SHALL update alarm_q normally and SHALL NOT alter ts.
REQ-014 Pointers SHALL wrap modulo DEPTH; LOG_CNT SHALL range 0..DEPTH inclusive.

Reset
REQ-015 On SIM_RST low, asynchronously: FIFO empty, LOG_RDY=0, LOG_CNT=0, LOG_OVF=0, LOG_DROPS=0, ts=0, alarm_q=0, MT01 history=0.
REQ-016 Because alarm_q resets to 0, alarms standing at reset release SHALL be logged on the first active edge.
REQ-017 Reset asserted mid-operation SHALL discard all entries; no partial entry SHALL survive.

Configuration
REQ-018 Macro CH77_LOG_DROPCNT_EN defined: LOG_DROPS SHALL count dropped entries, saturating at 255, cleared by LOG_CLR or reset.
REQ-019 Macro undefined: the LOG_DROPS port and its counter SHALL be absent; all other behaviour is identical.

Structure
REQ-020 Package ch77_log_pkg SHALL hold ALARM_W=9, the DEPTH and TS_W defaults, and the entry struct typedef (event bits plus timestamp).
REQ-021 Storage and pointers SHALL live in sub-module ch77_log_fifo, which has push, pop, clr, full, empty, and count.
REQ-022 Edge detection, timestamping, overflow handling, and the drop counter SHALL live in the top level.

Verification
REQ-023 Rise ALARM bit 3 (0x004) with ts=0x0012 -> after one edge LOG_RDY=1, LOG_DATA={0x004,0x0012}, LOG_CNT=1.
REQ-024 Rise bits 1 and 9 in the same cycle, and hold ALARM high for 20 cycles -> exactly one entry with event 0x101; no further entries.
REQ-025 Generate 9 distinct rises with no ACK (DEPTH=8) -> LOG_CNT=8, LOG_OVF=1, LOG_DROPS=1; pop order matches push order.
REQ-026 FIFO full, then pulse ACK in the same cycle as a new rise -> LOG_CNT stays 8, LOG_OVF stays 0, and the new entry appears at the tail.
REQ-027 Preload ts=0xFFFF, apply one MT01 pulse, then an alarm rise -> timestamp 0x0000; then LOG_CLR -> LOG_CNT=0, LOG_OVF=0, ts unchanged.
REQ-028 Release reset with ALARM=0x1FF, then assert reset mid-stream -> one entry 0x1FF at ts=0 after release; the later reset empties the FIFO immediately.
